// File: rtl/dice_traffic_demux_pkg.sv
// ---------------------------------------------------------------------------
// dice_traffic_demux_pkg
// Shared definitions for the receive side of the dice/traffic shared bus:
//   - traffic-light codes on the bus ({red,amber,green})
//   - traffic phase FSM state encoding (3 bits)
//   - legal dice face limits
//   - helpers to decode a light code and to step the phase ring
// ---------------------------------------------------------------------------
package dice_traffic_demux_pkg;

   localparam logic [2:0] LIGHT_RED       = 3'b100;
   localparam logic [2:0] LIGHT_RED_AMBER = 3'b110;
   localparam logic [2:0] LIGHT_GREEN     = 3'b001;
   localparam logic [2:0] LIGHT_AMBER     = 3'b010;

   localparam logic [2:0] DICE_MIN = 3'd1;
   localparam logic [2:0] DICE_MAX = 3'd6;

   typedef enum logic [2:0] {
      S_UNSYNC    = 3'd0,
      S_RED       = 3'd1,
      S_RED_AMBER = 3'd2,
      S_GREEN     = 3'd3,
      S_AMBER     = 3'd4
   } light_state_e;

   // Map a bus code to the phase it names; illegal codes map to S_UNSYNC.
   function automatic light_state_e code_to_state(input logic [2:0] code);
      case (code)
         LIGHT_RED:       return S_RED;
         LIGHT_RED_AMBER: return S_RED_AMBER;
         LIGHT_GREEN:     return S_GREEN;
         LIGHT_AMBER:     return S_AMBER;
         default:         return S_UNSYNC;
      endcase
   endfunction

   // Successor of a phase in the ring RED->RED_AMBER->GREEN->AMBER->RED.
   function automatic light_state_e next_phase(input light_state_e s);
      case (s)
         S_RED:       return S_RED_AMBER;
         S_RED_AMBER: return S_GREEN;
         S_GREEN:     return S_AMBER;
         S_AMBER:     return S_RED;
         default:     return S_UNSYNC;
      endcase
   endfunction

endpackage

// File: rtl/dice_traffic_demux_seq.sv
// ---------------------------------------------------------------------------
// traffic_seq_checker
// Tracks the traffic-light phase from bus samples, holds the last legal
// light code and flags illegal codes or illegal phase transitions.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            sample is for the traffic channel (sel=1)
//   resync        forget the tracked phase before judging this sample
//   code[2:0]     bus code {red,amber,green}
//   lights[2:0]   held last legal code
//   light_valid   a legal code has been captured since reset
//   seq_err       registered one-cycle error pulse
//   seq_err_nxt   combinational error for this sample (drives err counting)
// ---------------------------------------------------------------------------
module traffic_seq_checker
   import dice_traffic_demux_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       resync,
   input  logic [2:0] code,
   output logic [2:0] lights,
   output logic       light_valid,
   output logic       seq_err,
   output logic       seq_err_nxt
);

   light_state_e state;
   light_state_e cur_state;
   light_state_e rx_state;
   logic         code_legal;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      cur_state   = resync ? S_UNSYNC : state;
      rx_state    = code_to_state(code);
      code_legal  = (rx_state != S_UNSYNC);
      seq_err_nxt = 1'b0;
      if (en) begin
         if (!code_legal)
            seq_err_nxt = 1'b1;
         // From UNSYNC any legal code is accepted without a sequence check.
         else if ((cur_state != S_UNSYNC) && (rx_state != cur_state) &&
                  (rx_state != next_phase(cur_state)))
            seq_err_nxt = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_UNSYNC;
         lights      <= 3'b000;
         light_valid <= 1'b0;
         seq_err     <= 1'b0;
      end else begin
         seq_err <= seq_err_nxt;
         if (en) begin
            if (code_legal) begin
               // Also covers an illegal move: resync to what was received.
               state       <= rx_state;
               lights      <= code;
               light_valid <= 1'b1;
            end else begin
               state <= S_UNSYNC;   // lights hold last legal value
            end
         end
      end
   end

endmodule

// File: rtl/dice_traffic_demux.sv
// ---------------------------------------------------------------------------
// dice_traffic_demux
// Receive side of the 3-bit dice/traffic shared bus. Steers each sample to
// its channel, holds the last legal dice face and light state, checks dice
// encoding and light phase order, and counts dice changes and errors.
// All outputs registered, 1-cycle latency.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sel               0 = dice sample, 1 = traffic-light sample
//   result[2:0]       shared bus
//   dice_val/valid    last legal face (1..6) and captured flag
//   red/amber/green   held light state, light_valid captured flag
//   dice_err          pulse: dice code 0 or 7
//   seq_err           pulse: illegal light code or phase move
//   dice_changes      saturating count of dice face changes
//   err_count         saturating count of dice_err + seq_err pulses
// ---------------------------------------------------------------------------
module dice_traffic_demux
   import dice_traffic_demux_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic [2:0]       result,
   output logic [2:0]       dice_val,
   output logic             dice_valid,
   output logic             red,
   output logic             amber,
   output logic             green,
   output logic             light_valid,
   output logic             dice_err,
   output logic             seq_err,
   output logic [CNT_W-1:0] dice_changes,
   output logic [CNT_W-1:0] err_count
);

   logic       last_sel;
   logic       first_dice;
   logic       first_eff;
   logic       dice_legal;
   logic       dice_bad;
   logic       seq_err_nxt;
   logic       resync;
   logic [2:0] lights;

   // A 0->1 sel edge drops the tracked phase so switching back to the
   // traffic channel never raises a false sequence error.
   assign resync     = sel & ~last_sel;
   // A 1->0 sel edge makes the next dice sample a "first" sample.
   assign first_eff  = first_dice | last_sel;
   assign dice_legal = (result >= DICE_MIN) && (result <= DICE_MAX);
   assign dice_bad   = ~sel & ~dice_legal;

   traffic_seq_checker u_seq (
      .clk         (clk),
      .rst         (rst),
      .en          (sel),
      .resync      (resync),
      .code        (result),
      .lights      (lights),
      .light_valid (light_valid),
      .seq_err     (seq_err),
      .seq_err_nxt (seq_err_nxt)
   );

   assign red   = lights[2];
   assign amber = lights[1];
   assign green = lights[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         dice_val     <= 3'd0;
         dice_valid   <= 1'b0;
         dice_err     <= 1'b0;
         dice_changes <= '0;
         err_count    <= '0;
         last_sel     <= 1'b0;
         first_dice   <= 1'b1;
      end else begin
         last_sel <= sel;
         dice_err <= dice_bad;

         if (!sel) begin
            if (dice_legal) begin
               if (!first_eff && (result != dice_val) && (dice_changes != '1))
                  dice_changes <= dice_changes + 1'b1;
               dice_val   <= result;
               dice_valid <= 1'b1;
               first_dice <= 1'b0;
            end else begin
               // Keep the "first" status across an illegal sample.
               first_dice <= first_eff;
            end
         end

         // dice_bad and seq_err_nxt are exclusive through sel, so at most
         // one increment per cycle.
         if ((dice_bad || seq_err_nxt) && (err_count != '1))
            err_count <= err_count + 1'b1;
      end
   end

endmodule
